// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream loader and its element counter.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  // Width of an element counter spanning 0..n*n-1.
  function automatic int cnt_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // LSB of element (r,c) in a row-major flattened n x n bus of dw-bit elements.
  function automatic int elem_lsb(input int r, input int c, input int n, input int dw);
    return (r * n + c) * dw;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_w(3);

endpackage

// File: rtl/matrix_elem_counter.sv
// Element counter for an N x N matrix: linear index plus row/col split of that index.
module matrix_elem_counter
  import matrix_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = cnt_w(N),
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [IW-1:0] idx,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          wrap
);

  assign wrap = inc && (idx == IW'(N * N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (clr || wrap) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
      if (col == RW'(N - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams A then B into registered row-major buses for the N x N multiplier.
// Optional build macro MATRIX_LOADER_TRANSPOSE_B_EN: B arrives column-major.
//
// state  | meaning
// LOAD_A | accepting A elements, idx counts 0..N*N-1
// LOAD_B | accepting B elements, idx counts 0..N*N-1
// FULL   | pair held on A_flat/B_flat with out_valid, input stalled
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*DW-1:0] A_flat,
  output logic [N*N*DW-1:0] B_flat,
  output logic              err
);

  localparam int IW = cnt_w(N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx;
  logic [RW-1:0]     row, col;
  logic [RW-1:0]     b_r, b_c;
  logic              wrap, xfer, a_we, b_we, frame_err;
  logic [N*N*DW-1:0] a_q, b_q;
  logic              err_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q == FULL);
  assign xfer      = in_valid && in_ready && !clear;
  assign a_we      = xfer && (state_q == LOAD_A);
  assign b_we      = xfer && (state_q == LOAD_B);
  // in_last must coincide exactly with the final B element.
  assign frame_err = xfer && (in_last != ((state_q == LOAD_B) && wrap));

  matrix_elem_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer),
    .clr   (clear),
    .idx   (idx),
    .row   (row),
    .col   (col),
    .wrap  (wrap)
  );

`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
  assign b_r = col;
  assign b_c = row;
`else
  assign b_r = row;
  assign b_c = col;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A:  if (xfer && wrap) state_d = LOAD_B;
        LOAD_B:  if (xfer && wrap) state_d = FULL;
        FULL:    if (out_ready)    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (a_we && int'(idx) == r * N + c)
            a_q[elem_lsb(r, c, N, DW) +: DW] <= in_data;
          if (b_we && int'(b_r) == r && int'(b_c) == c)
            b_q[elem_lsb(r, c, N, DW) +: DW] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (clear)     err_q <= 1'b0;
    else if (frame_err) err_q <= 1'b1;
  end

  assign A_flat = a_q;
  assign B_flat = b_q;
  assign err    = err_q;

endmodule
